// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared RV64I decode definitions for the IF/ID stage.
//   - OPCODE_* : major opcode values (instr[6:0])
//   - opclass_t: 4-bit operation class presented to execute
//   - imm_fmt_t: immediate format selector for rv_imm_gen
package rv_decode_pkg;

    localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPCODE_OP        = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
    localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPCODE_FENCE     = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        OPC_NONE      = 4'd0,
        OPC_LUI       = 4'd1,
        OPC_AUIPC     = 4'd2,
        OPC_JAL       = 4'd3,
        OPC_JALR      = 4'd4,
        OPC_BRANCH    = 4'd5,
        OPC_LOAD      = 4'd6,
        OPC_STORE     = 4'd7,
        OPC_OP_IMM    = 4'd8,
        OPC_OP_IMM_32 = 4'd9,
        OPC_OP        = 4'd10,
        OPC_OP_32     = 4'd11,
        OPC_SYSTEM    = 4'd12,
        OPC_FENCE     = 4'd13,
        OPC_MULDIV    = 4'd14
    } opclass_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_t;

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational immediate extraction, sign-extended from instr[31].
//   i_instr : instruction bits [31:7] (opcode bits carry no immediate data)
//   i_fmt   : immediate format select
//   o_imm   : XLEN-wide immediate (zero for IMM_NONE)
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:7]     i_instr,
    input  imm_fmt_t        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic w_sign;
    assign w_sign = i_instr[31];

    always_comb begin
        o_imm = '0;
        case (i_fmt)
            IMM_I: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
            IMM_S: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'h000};
            IMM_J: o_imm = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/ifid_decode.sv
// ifid_decode: IF/ID pipeline register with RV64I decode.
// Captures one fetch beat per handshake, decodes fields/immediate/opclass
// and presents the result to execute one cycle later.
// Optional feature: `define DECODE_RVM_EN to decode funct7=0000001 on
// OP/OP_32 as MULDIV; otherwise those encodings are illegal.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_valid/instr/pc   : fetch beat
//   id_ready            : stage can accept a beat (!id_valid || ex_ready)
//   flush               : redirect from EX, drops pending and incoming beats
//   ex_ready            : execute consumes id_* this cycle
//   id_*                : registered decoded beat
module ifid_decode
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [XLEN-1:0]    if_pc,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               id_valid,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_npc,
    output logic [4:0]         id_rs1,
    output logic [4:0]         id_rs2,
    output logic [4:0]         id_rd,
    output logic [2:0]         id_funct3,
    output logic [6:0]         id_funct7,
    output logic [XLEN-1:0]    id_imm,
    output logic [3:0]         id_opclass,
    output logic               id_illegal,
    output logic               id_halt
);

    logic [6:0]      w_opcode;
    logic [6:0]      w_funct7;
    logic            w_ready;
    logic            w_accept;
    logic            w_halt;
    logic            w_illegal;
    opclass_t        w_opclass;
    imm_fmt_t        w_fmt;
    logic [XLEN-1:0] w_imm;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_npc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_imm;
    opclass_t        r_opclass;
    logic            r_illegal;
    logic            r_halt;

    assign w_opcode = if_instr[6:0];
    assign w_funct7 = if_instr[31:25];
    assign w_halt   = (if_instr == '0);
    assign w_ready  = !r_valid || ex_ready;
    assign w_accept = if_valid && w_ready && !flush;

    // Illegal encodings decode as OPC_NONE with no immediate. The all-zero
    // halt marker is carved out ahead of the low-bits check.
    always_comb begin
        w_fmt     = IMM_NONE;
        w_opclass = OPC_NONE;
        w_illegal = 1'b0;
        if (w_halt) begin
            w_illegal = 1'b0;
        end else if (if_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPCODE_LUI:       begin w_opclass = OPC_LUI;       w_fmt = IMM_U; end
                OPCODE_AUIPC:     begin w_opclass = OPC_AUIPC;     w_fmt = IMM_U; end
                OPCODE_JAL:       begin w_opclass = OPC_JAL;       w_fmt = IMM_J; end
                OPCODE_JALR:      begin w_opclass = OPC_JALR;      w_fmt = IMM_I; end
                OPCODE_BRANCH:    begin w_opclass = OPC_BRANCH;    w_fmt = IMM_B; end
                OPCODE_LOAD:      begin w_opclass = OPC_LOAD;      w_fmt = IMM_I; end
                OPCODE_STORE:     begin w_opclass = OPC_STORE;     w_fmt = IMM_S; end
                OPCODE_OP_IMM:    begin w_opclass = OPC_OP_IMM;    w_fmt = IMM_I; end
                OPCODE_OP_IMM_32: begin w_opclass = OPC_OP_IMM_32; w_fmt = IMM_I; end
                OPCODE_SYSTEM:    begin w_opclass = OPC_SYSTEM;    w_fmt = IMM_I; end
                OPCODE_FENCE:     begin w_opclass = OPC_FENCE;     w_fmt = IMM_I; end
                OPCODE_OP, OPCODE_OP_32: begin
                    if (w_funct7 == FUNCT7_BASE || w_funct7 == FUNCT7_ALT) begin
                        if (w_opcode == OPCODE_OP) begin
                            w_opclass = OPC_OP;
                        end else begin
                            w_opclass = OPC_OP_32;
                        end
`ifdef DECODE_RVM_EN
                    end else if (w_funct7 == FUNCT7_MULDIV) begin
                        w_opclass = OPC_MULDIV;
`endif
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr (if_instr[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // Stall needs no explicit hold: w_ready is low, so nothing loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_npc     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_imm     <= '0;
            r_opclass <= OPC_NONE;
            r_illegal <= 1'b0;
            r_halt    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= if_pc;
            r_npc     <= if_pc + XLEN'(4);
            r_rs1     <= if_instr[19:15];
            r_rs2     <= if_instr[24:20];
            r_rd      <= if_instr[11:7];
            r_funct3  <= if_instr[14:12];
            r_funct7  <= w_funct7;
            r_imm     <= w_imm;
            r_opclass <= w_opclass;
            r_illegal <= w_illegal;
            r_halt    <= w_halt;
        end else if (r_valid && ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign id_ready   = w_ready;
    assign id_valid   = r_valid;
    assign id_pc      = r_pc;
    assign id_npc     = r_npc;
    assign id_rs1     = r_rs1;
    assign id_rs2     = r_rs2;
    assign id_rd      = r_rd;
    assign id_funct3  = r_funct3;
    assign id_funct7  = r_funct7;
    assign id_imm     = r_imm;
    assign id_opclass = r_opclass;
    assign id_illegal = r_illegal;
    assign id_halt    = r_halt;

endmodule

// File: tb/tb_ifid_decode.sv
// tb_ifid_decode: directed scoreboard bench for ifid_decode.
module tb_ifid_decode;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] id_npc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [63:0] id_imm;
    logic [3:0]  id_opclass;
    logic        id_illegal;
    logic        id_halt;

    ifid_decode #(
        .XLEN    (64),
        .INSTR_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_npc     (id_npc),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_funct3  (id_funct3),
        .id_funct7  (id_funct7),
        .id_imm     (id_imm),
        .id_opclass (id_opclass),
        .id_illegal (id_illegal),
        .id_halt    (id_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [3:0]  opc;
        logic        ill;
        logic        halt;
    } exp_t;

    exp_t q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef DECODE_RVM_EN
    localparam logic [3:0] MUL_OPC = 4'd14;
    localparam logic       MUL_ILL = 1'b0;
`else
    localparam logic [3:0] MUL_OPC = 4'd0;
    localparam logic       MUL_ILL = 1'b1;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a beat on the fetch side and record what it must decode to.
    task automatic drive(input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] npc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [63:0] imm, input logic [3:0] opc,
                         input logic ill, input logic halt, input bit push);
        exp_t e;
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        if (push) begin
            e.pc = pc; e.npc = npc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
            e.imm = imm; e.opc = opc; e.ill = ill; e.halt = halt;
            q.push_back(e);
        end
    endtask

    task automatic check_beat(input string tag);
        exp_t e;
        chk({tag, ".valid"}, {63'd0, id_valid}, 64'd1);
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s.queue: observed=empty expected=entry", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, ".pc"},   id_pc, e.pc);
            chk({tag, ".npc"},  id_npc, e.npc);
            chk({tag, ".rd"},   {59'd0, id_rd}, {59'd0, e.rd});
            chk({tag, ".rs1"},  {59'd0, id_rs1}, {59'd0, e.rs1});
            chk({tag, ".rs2"},  {59'd0, id_rs2}, {59'd0, e.rs2});
            chk({tag, ".imm"},  id_imm, e.imm);
            chk({tag, ".opc"},  {60'd0, id_opclass}, {60'd0, e.opc});
            chk({tag, ".ill"},  {63'd0, id_illegal}, {63'd0, e.ill});
            chk({tag, ".halt"}, {63'd0, id_halt}, {63'd0, e.halt});
        end
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; ex_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst.valid", {63'd0, id_valid}, 64'd0);
        chk("rst.pc", id_pc, 64'd0);
        chk("rst.imm", id_imm, 64'd0);
        chk("rst.opc", {60'd0, id_opclass}, 64'd0);
        chk("rst.ready", {63'd0, id_ready}, 64'd1);
        reset = 1'b0;

        // back-to-back stream, one beat per cycle
        drive(32'h00500093, 64'h1000, 64'h1004, 5'd1, 5'd0, 5'd5, 64'd5, 4'd8, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("addi");
        drive(32'hFE000EE3, 64'h2000, 64'h2004, 5'd29, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC, 4'd5, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("beq");
        drive(32'h800000B7, 64'h2004, 64'h2008, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFF80000000, 4'd1, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("lui");
        drive(32'h0020B423, 64'h4000, 64'h4004, 5'd8, 5'd1, 5'd2, 64'd8, 4'd7, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("sd");
        drive(32'hFFF10113, 64'h4004, 64'h4008, 5'd2, 5'd2, 5'd31, 64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("addi_neg");
        drive(32'h40000033, 64'h4008, 64'h400C, 5'd0, 5'd0, 5'd0, 64'd0, 4'd10, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("sub");
        drive(32'h00000000, 64'h3000, 64'h3004, 5'd0, 5'd0, 5'd0, 64'd0, 4'd0, 1'b0, 1'b1, 1);
        @(negedge clk); check_beat("halt");
        drive(32'h00000010, 64'h3004, 64'h3008, 5'd0, 5'd0, 5'd0, 64'd0, 4'd0, 1'b1, 1'b0, 1);
        @(negedge clk); check_beat("lowbits");
        drive(32'h10000033, 64'h3008, 64'h300C, 5'd0, 5'd0, 5'd0, 64'd0, 4'd0, 1'b1, 1'b0, 1);
        @(negedge clk); check_beat("badf7");
        drive(32'h022081B3, 64'hFFFFFFFFFFFFFFFC, 64'h0, 5'd3, 5'd1, 5'd2, 64'd0, MUL_OPC, MUL_ILL, 1'b0, 1);
        @(negedge clk); check_beat("mul_wrap");
        if_valid = 1'b0;
        @(negedge clk);
        chk("drain.valid", {63'd0, id_valid}, 64'd0);

        // stall: held beat stays bit-stable, new beat waits
        drive(32'h00500093, 64'h5000, 64'h5004, 5'd1, 5'd0, 5'd5, 64'd5, 4'd8, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("stall_a");
        ex_ready = 1'b0;
        drive(32'h800000B7, 64'h5004, 64'h5008, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFF80000000, 4'd1, 1'b0, 1'b0, 1);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.ready", {63'd0, id_ready}, 64'd0);
            chk("stall.valid", {63'd0, id_valid}, 64'd1);
            chk("stall.pc", id_pc, 64'h5000);
            chk("stall.imm", id_imm, 64'd5);
            chk("stall.opc", {60'd0, id_opclass}, 64'd8);
        end
        ex_ready = 1'b1;
        @(negedge clk); check_beat("stall_b");
        if_valid = 1'b0;
        @(negedge clk);
        chk("stall_drain.valid", {63'd0, id_valid}, 64'd0);

        // flush drops a same-cycle beat
        flush = 1'b1;
        drive(32'h00500093, 64'h6000, 64'h6004, 5'd1, 5'd0, 5'd5, 64'd5, 4'd8, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("flush_in.valid", {63'd0, id_valid}, 64'd0);
        flush = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_in.after", {63'd0, id_valid}, 64'd0);

        // flush kills a stalled beat and the incoming one
        drive(32'h00008067, 64'h7000, 64'h7004, 5'd0, 5'd1, 5'd0, 64'd0, 4'd4, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("jalr");
        ex_ready = 1'b0; flush = 1'b1;
        drive(32'h00500093, 64'h7004, 64'h7008, 5'd1, 5'd0, 5'd5, 64'd5, 4'd8, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("flush_stall.valid", {63'd0, id_valid}, 64'd0);
        flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
        @(negedge clk);
        chk("flush_stall.after", {63'd0, id_valid}, 64'd0);

        // reset in the middle of a stall
        drive(32'hFE000EE3, 64'h8000, 64'h8004, 5'd29, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC, 4'd5, 1'b0, 1'b0, 1);
        @(negedge clk); check_beat("pre_rst");
        ex_ready = 1'b0; if_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("mid_rst.valid", {63'd0, id_valid}, 64'd0);
        chk("mid_rst.pc", id_pc, 64'd0);
        chk("mid_rst.imm", id_imm, 64'd0);
        chk("mid_rst.opc", {60'd0, id_opclass}, 64'd0);
        reset = 1'b0; ex_ready = 1'b1;

        chk("queue.empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifid_decode.md
Name: ifid_decode

Overview:
- Downstream neighbour of the fetch stage. Captures each fetched instruction and its PC into the IF/ID pipeline register.
- Decodes RV64I fields, immediates and the operation class, and presents one decoded instruction per handshake to the execute stage.
- Provides backpressure to fetch and a flush path for taken branches resolved in EX.

Parameters:
- XLEN, 64, PC/immediate width
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch beat valid (fetch data_ack)
- if_instr  in  INSTR_W  fetched instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage can accept a beat this cycle
- flush  in  1  taken branch/redirect from EX (EXIF_branch)
- ex_ready  in  1  execute accepts id_* this cycle
- id_valid  out  1  decoded beat valid
- id_pc  out  XLEN  captured PC
- id_npc  out  XLEN  id_pc + 4
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_funct3  out  3;  id_funct7  out  7
- id_imm  out  XLEN  sign-extended immediate
- id_opclass  out  4  opclass_t encoding
- id_illegal  out  1  undecodable instruction
- id_halt  out  1  instruction == 32'h0 (simulation stop marker)

Behaviour:
- Reset: all outputs are 0; id_valid=0; id_opclass=OPC_NONE (0).
- id_ready is combinational: !id_valid || ex_ready.
- Accept condition: if_valid && id_ready && !flush. On accept, the decoded fields are registered, giving 1-cycle latency from if_* to id_*. id_valid=1 the next cycle.
- Consume condition: id_valid && ex_ready. If there is no accept in the same cycle, id_valid goes to 0. Accept and consume in the same cycle give back-to-back throughput of 1 per cycle.
- Stall: while id_valid && !ex_ready, all id_* outputs are held bit-stable and id_ready=0.
- Flush has priority over everything except reset. Next cycle id_valid=0. Any same-cycle if_valid beat is dropped. Data fields may keep stale values.
- Reset mid-stall or mid-flush returns the block to the reset state next cycle.
- Decode:
  - opcode = instr[6:0]; rd[11:7]; funct3[14:12]; rs1[19:15]; rs2[24:20]; funct7[31:25].
  - Immediate formats: I = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; U = {[31:12],12'h0}; J = {[31],[19:12],[20],[30:21],0}.
  - All immediates are sign-extended from instr[31] to XLEN. For R-type, id_imm=0.
  - opclass values: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_IMM_32, OP, OP_32, SYSTEM, FENCE, MULDIV.
- id_illegal=1 in any of these cases: instr[1:0] != 2'b11; unknown opcode; funct7 not in {0000000, 0100000} for OP/OP_32 (subject to the optional feature).
- Instruction 32'h0 gives id_halt=1, id_illegal=0, id_valid=1. Downstream performs the $finish.
- id_npc wraps modulo 2^XLEN.

Optional Feature:
- Macro: DECODE_RVM_EN.
- Defined: OP/OP_32 with funct7=0000001 decodes to id_opclass=MULDIV, id_illegal=0.
- Undefined: the same encodings give id_illegal=1 and id_opclass=OPC_NONE.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams (OPCODE_LUI=7'b0110111, etc.)
  - opclass_t enum (4-bit)
  - imm_fmt_t enum (I, S, B, U, J, NONE)
- Sub-module rv_imm_gen: purely combinational (instr, imm_fmt_t) -> XLEN immediate. It is instantiated once before the pipeline register.

Test Plan:
- addi x1,x0,5 (0x00500093, pc 0x1000), ex_ready=1 -> next cycle: id_valid=1, rd=1, rs1=0, imm=5, opclass=OP_IMM, npc=0x1004.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFFFFFFFFFC, opclass=BRANCH. lui x1,0x80000 (0x800000B7) -> imm=0xFFFFFFFF80000000.
- Hold ex_ready=0 for 3 cycles with id_valid=1 and a new if_valid beat -> id_ready=0, outputs unchanged. On release, the held beat is consumed and the new beat is captured next cycle.
- flush=1 in the same cycle as if_valid=1 (0x00500093) -> next cycle id_valid=0; that beat never appears.
- if_instr=0x00000000 -> id_halt=1, id_illegal=0. if_instr=0x00000013 with bits[1:0] forced to 00 -> id_illegal=1.
- mul x3,x1,x2 (0x022081B3): DECODE_RVM_EN defined -> opclass=MULDIV; undefined -> id_illegal=1. Also drive pc=0xFFFFFFFFFFFFFFFC -> npc=0.
